// File: rtl/ama_riscv_fetch_buffer_pkg.sv
// ============================================================================
// Module      : ama_riscv_fetch_buffer_pkg
// Description : Shared constants and the packed queue-entry type used by the
//               instruction fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NOP
`define NOP 32'h0000_0013
`endif

package ama_riscv_fetch_buffer_pkg;

    localparam logic [31:0] C_NOP_INST = `NOP;
    localparam int          FB_DEPTH   = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fb_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ama_riscv_fb_fifo.sv
// ============================================================================
// Module      : ama_riscv_fb_fifo
// Description : Synchronous FIFO of {pc,inst} entries with push, pop, flush
//               and an occupancy count; head is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ama_riscv_fb_fifo
    import ama_riscv_fetch_buffer_pkg::*;
#(
    parameter  int DEPTH = FB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [63:0]   push_data_i,
    input  logic          pop_i,
    output logic [63:0]   head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty_o   = (count_q == '0);
    assign w_do_push = push_i && !flush_i;
    assign w_do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            // Pointers are left where the writer is, so the queue is empty
            // without having to rewind anything.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_do_push && !w_do_pop && (count_q == C_FULL)));

endmodule

`default_nettype wire

// File: rtl/ama_riscv_fetch_buffer.sv
// ============================================================================
// Module      : ama_riscv_fetch_buffer
// Description : Instruction prefetch queue between the IMEM read port and ID.
//               Optional same-cycle bypass of IMEM data when the queue is
//               empty is enabled by defining AMA_FB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ama_riscv_fetch_buffer
    import ama_riscv_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = FB_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_inst,
    output logic [31:0]        id_pc
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   C_DEPTH = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic          drop_q, drop_d;

    logic [31:0]   w_issue_pc;
    logic [CW:0]   w_occupancy;
    logic          w_rsp_valid;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic          w_fifo_empty;
    fb_entry_t     w_push_entry;
    fb_entry_t     w_head;

    // Outstanding words (queued plus in flight) bound issue, so a response
    // always finds a free slot.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, inflight_q};
    assign imem_en     = rst && (redirect || (w_occupancy < C_DEPTH));
    assign w_issue_pc  = redirect ? word_align(redirect_pc) : fetch_pc_q;
    assign imem_addr   = w_issue_pc[IMEM_AW+1:2];

    // The response landing in a redirect cycle belongs to the old stream.
    assign w_rsp_valid = inflight_q && !drop_q && !redirect;

`ifdef AMA_FB_BYPASS_EN
    assign w_bypass = w_rsp_valid && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push       = w_rsp_valid && !(w_bypass && id_ready);
    assign w_pop        = id_ready && !w_fifo_empty && !redirect;
    assign w_push_entry = '{pc: pc_q, inst: imem_rdata};
    assign id_valid     = !w_fifo_empty || w_bypass;

    always_comb begin
        id_inst = C_NOP_INST;
        id_pc   = 32'h0000_0000;
`ifdef AMA_FB_BYPASS_EN
        if (w_bypass) begin
            id_inst = imem_rdata;
            id_pc   = pc_q;
        end else if (!w_fifo_empty) begin
            id_inst = w_head.inst;
            id_pc   = w_head.pc;
        end
`else
        if (!w_fifo_empty) begin
            id_inst = w_head.inst;
            id_pc   = w_head.pc;
        end
`endif
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inflight_d = imem_en;
        drop_d     = drop_q;
        if (imem_en) begin
            fetch_pc_d = w_issue_pc + 32'd4;
            pc_d       = w_issue_pc;
        end
        // The request issued alongside a redirect is the new target: keep it.
        if (redirect) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= 32'h0000_0000;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    ama_riscv_fb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .empty_o     (w_fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_fetch_buffer.sv
// ============================================================================
// Module      : tb_ama_riscv_fetch_buffer
// Description : Self-checking bench for the fetch buffer: timing tables plus
//               a PC scoreboard driven by an independent issue/credit model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ama_riscv_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          IMEM_AW  = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef AMA_FB_BYPASS_EN
    localparam int          LAT = 1;
`else
    localparam int          LAT = 2;
`endif

    logic               clk;
    logic               rst;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               id_valid;
    logic               id_ready;
    logic [31:0]        id_inst;
    logic [31:0]        id_pc;

    int n_checks = 0;
    int n_errors = 0;

    ama_riscv_fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IMEM returns its own word address, one cycle after the request.
    always @(posedge clk) begin
        imem_rdata <= imem_en ? {{(32-IMEM_AW){1'b0}}, imem_addr} : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {{(32-IMEM_AW){1'b0}}, pc[IMEM_AW+1:2]};
    endfunction

    // Scoreboard: model of outstanding PCs, checked every cycle at negedge.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pcq;
    logic        m_infl;

    initial begin
        logic        exp_en, rsp, byp, exp_valid;
        logic [31:0] issue_pc, head;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_q.delete();
                m_pc   = RESET_PC;
                m_pcq  = 32'h0;
                m_infl = 1'b0;
            end else begin
                exp_en   = redirect || (m_q.size() + int'(m_infl) < DEPTH);
                issue_pc = redirect ? {redirect_pc[31:2], 2'b00} : m_pc;
                chk("sb_imem_en", {31'b0, imem_en}, {31'b0, exp_en});
                if (exp_en) begin
                    chk("sb_imem_addr", 32'(imem_addr), 32'(issue_pc[IMEM_AW+1:2]));
                end
                rsp = m_infl && !redirect;
                byp = 1'b0;
`ifdef AMA_FB_BYPASS_EN
                byp = rsp && (m_q.size() == 0);
`endif
                exp_valid = (m_q.size() != 0) || byp;
                chk("sb_id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
                if (exp_valid) begin
                    head = byp ? m_pcq : m_q[0];
                    chk("sb_id_pc", id_pc, head);
                    chk("sb_id_inst", id_inst, inst_of(head));
                end else begin
                    chk("sb_idle_inst", id_inst, NOP_INST);
                    chk("sb_idle_pc", id_pc, 32'h0);
                end
                if (redirect) begin
                    m_q.delete();
                end else begin
                    if (exp_valid && id_ready && !byp) void'(m_q.pop_front());
                    if (rsp && !(byp && id_ready)) m_q.push_back(m_pcq);
                end
                if (exp_en) begin
                    m_pcq = issue_pc;
                    m_pc  = issue_pc + 32'd4;
                end
                m_infl = exp_en;
            end
        end
    end

    typedef struct {
        logic               rdy;
        logic               exp_en;
        logic [IMEM_AW-1:0] exp_addr;
        logic               exp_valid;
        logic [31:0]        exp_pc;
    } vec_t;

    vec_t vec [16];

    task automatic do_reset(input logic rdy);
        rst      = 1'b0;
        redirect = 1'b0;
        id_ready = rdy;
        #1;
        chk("rst_imem_en", {31'b0, imem_en}, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_id_inst", id_inst, NOP_INST);
        repeat (2) tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;

        // Rows 0-7: streaming with id_ready=1; rows 8-15: id_ready=0 from reset.
        for (int i = 0; i < 8; i++) begin
            vec[i]     = '{1'b1, 1'b1, IMEM_AW'(i), (i >= LAT),
                           32'((i >= LAT) ? (i - LAT) * 4 : 0)};
            vec[8 + i] = '{1'b0, (i < DEPTH), IMEM_AW'(i), (i >= LAT), 32'h0};
        end

        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 8) do_reset(vec[i].rdy);
            else tick();
            id_ready = vec[i].rdy;
            #2;
            chk($sformatf("tbl%0d_en", i), {31'b0, imem_en}, {31'b0, vec[i].exp_en});
            if (vec[i].exp_en) chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(vec[i].exp_addr));
            chk($sformatf("tbl%0d_valid", i), {31'b0, id_valid}, {31'b0, vec[i].exp_valid});
            if (vec[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), id_pc, vec[i].exp_pc);
                chk($sformatf("tbl%0d_inst", i), id_inst, inst_of(vec[i].exp_pc));
            end
        end

        // Release back-pressure: scoreboard checks order, no loss or duplicates.
        tick();
        id_ready = 1'b1;
        repeat (10) tick();

        // Redirect with three queued words and one request in flight.
        do_reset(1'b0);
        repeat (4) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        id_ready    = 1'b1;
        #2;
        chk("redir_en", {31'b0, imem_en}, 32'h1);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        tick();
        redirect = 1'b0;
        repeat (8) tick();

        // Unaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        #2;
        chk("unalign_addr", 32'(imem_addr), 32'h80);
        tick();
        redirect = 1'b0;
        repeat (6) tick();

        // Back-to-back redirects: only the second stream may be delivered.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #2;
            if (id_valid) got = 1'b1;
            else tick();
        end
        chk("b2b_seen_valid", {31'b0, got}, 32'h1);
        if (got) chk("b2b_first_pc", id_pc, 32'h0000_0300);
        repeat (6) tick();

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        repeat (8) tick();

        // Asynchronous reset mid-stream with two words queued.
        do_reset(1'b0);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_id_valid", {31'b0, id_valid}, 32'h0);
        chk("async_id_inst", id_inst, NOP_INST);
        chk("async_id_pc", id_pc, 32'h0);
        chk("async_imem_en", {31'b0, imem_en}, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        #2;
        chk("restart_en", {31'b0, imem_en}, 32'h1);
        chk("restart_addr", 32'(imem_addr), 32'(RESET_PC[IMEM_AW+1:2]));
        id_ready = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ama_riscv_fetch_buffer.md
Name: ama_riscv_fetch_buffer

Overview:
Instruction prefetch queue between the synchronous IMEM read port and the ID stage.
- Issues one IMEM word-read per cycle while it has credit.
- Captures each instruction with its PC in a small FIFO and presents it to ID over a valid/ready handshake.
- On a control-flow redirect (branch/jump resolved in EX) it flushes all queued and in-flight fetches and restarts at the new PC. This decouples IMEM latency from ID stalls.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset
IMEM_AW, 14, IMEM word-address width (PC bits [IMEM_AW+1:2])

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
redirect  in  1  flush and restart fetch at redirect_pc this cycle
redirect_pc  in  32  target PC; bits [1:0] ignored (treated as 0)
imem_en  out  1  IMEM read request this cycle
imem_addr  out  IMEM_AW  IMEM word address
imem_rdata  in  32  IMEM read data, valid exactly 1 cycle after imem_en
id_valid  out  1  id_inst/id_pc hold a valid instruction
id_ready  in  1  ID accepts the instruction this cycle
id_inst  out  32  instruction to ID; `NOP when id_valid=0
id_pc  out  32  PC of id_inst; 0 when id_valid=0

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; count=0; rd/wr pointers=0; inflight_q=0; drop_q=0.
  - Outputs: imem_en=0, id_valid=0, id_inst=`NOP, id_pc=0.
- State:
  - fetch_pc: next PC to request.
  - inflight_q: a request was issued last cycle.
  - pc_q: PC of that request.
  - drop_q: discard the response arriving this cycle.
  - FIFO of {pc,inst}.
  - count: 0..DEPTH.
- Issue:
  - imem_en = (count + inflight_q < DEPTH) || redirect. A redirect always has credit because the FIFO empties.
  - imem_addr = redirect ? redirect_pc[IMEM_AW+1:2] : fetch_pc[IMEM_AW+1:2].
  - On issue: fetch_pc <= issued_pc + 4 (mod 2^32); inflight_q<=1; pc_q<=issued_pc. Otherwise inflight_q<=0.
- Response:
  - When inflight_q=1 and drop_q=0, push {pc_q, imem_rdata} into the FIFO.
  - A push can never overflow, guaranteed by the credit rule. Any overflow attempt is an assertion failure.
- Pop:
  - id_valid = (count != 0).
  - A pop happens when id_valid && id_ready.
  - id_inst/id_pc = FIFO head.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - Same edge: count<=0, rd_ptr<=wr_ptr.
  - Any push arriving in the redirect cycle is discarded.
  - drop_q<=0, because the request issued in the redirect cycle is the new target and must be kept.
  - An ID pop in the redirect cycle is ignored; ID clears itself.
- Latency:
  - imem_en cycle N -> FIFO write at edge N+1 -> id_valid in cycle N+2.
  - Sustained throughput is 1 instr/cycle with id_ready=1 and DEPTH>=4.
- Back-pressure: id_ready=0 holds the head stable. Issue stops when count+inflight_q=DEPTH.
- Wrap: pointers are log2(DEPTH) bits and wrap naturally. fetch_pc wraps 32'hFFFF_FFFC -> 0.
- Reset mid-operation: all state is cleared asynchronously. The IMEM response in the cycle after reset release is ignored because inflight_q=0.

Optional Feature:
AMA_FB_BYPASS_EN
- Defined: when count=0 and a valid (non-dropped) response arrives, id_valid=1 in that same cycle with id_inst=imem_rdata, id_pc=pc_q.
  - If id_ready=1, the word is consumed and not written to the FIFO. Otherwise it is pushed normally.
  - Latency becomes N+1.
  - Bypass is suppressed in a redirect cycle.
- Undefined: no combinational path from imem_rdata to id_*; latency N+2.

Decomposition:
- Shared defines: `NOP (32'h0000_0013) and FB_DEPTH default added to ama_riscv_defines.v.
- One sub-module, ama_riscv_fb_fifo: synchronous FIFO, width 64 ({pc,inst}), depth DEPTH, with push/pop/flush and count. Top level holds the fetch_pc, credit, inflight and redirect logic.

Test Plan:
- Reset release with id_ready=1 and IMEM preloaded with inst = word address -> imem_addr 0,1,2,...
  - id_valid first high 2 cycles after first imem_en.
  - id_pc 0,4,8,... one per cycle.
- Hold id_ready=0 from reset -> exactly DEPTH=4 requests issued, count=4, imem_en=0 thereafter.
  - On id_ready=1, head id_pc=0 and no word is lost or duplicated.
- redirect=1, redirect_pc=0x100 while count=3 and a request is in flight -> same-cycle imem_addr=0x40.
  - Next id_pc=0x100; stale PCs never appear on id_pc.
- redirect_pc=0x203 -> fetch at word 0x80, id_pc=0x200.
  - Back-to-back redirects on 2 consecutive cycles (0x100, 0x300) -> only 0x300 stream is delivered.
- Assert rst=0 asynchronously mid-stream with count=2 -> id_valid=0, id_inst=`NOP immediately.
  - After release, fetch restarts at RESET_PC.
- AMA_FB_BYPASS_EN defined, empty FIFO, id_ready=1 -> id_valid in cycle N+1 with id_inst=imem_rdata, count stays 0.
  - Repeat with id_ready=0 -> word held, count=1.
